// File: rtl/pipe_mult_wt_if.sv
// Operand/result handshake bundle for pipe_mult_wt: valid/ready on the operand side
// and on the product side.
interface pipe_mult_wt_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipe_mult_wt.sv
// Pipelined WIDTH x WIDTH multiplier (signed or unsigned per pair): Wallace-tree carry-save
// reduction spread over STAGES register banks, final carry-propagate add into the output bank.
module pipe_mult_wt #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input logic           clk,
  input logic           rst_n,
  pipe_mult_wt_if.slave bus
);
  localparam int P  = 2 * WIDTH;
  localparam int R0 = WIDTH + 1;

  function automatic int next_rows(int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int rows_at(int lv);
    int n = R0;
    for (int i = 0; i < lv; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int num_levels();
    int n = R0;
    int l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = next_rows(n);
        l++;
      end
    end
    return l;
  endfunction

  localparam int NL = num_levels();

  // Register bank k (1..STAGES-1) sits after level (k*(NL+1))/STAGES; the last bank is out.
  function automatic int regs_after(int lv);
    int c = 0;
    for (int k = 1; k < STAGES; k++) begin
      if ((k * (NL + 1)) / STAGES == lv) c++;
    end
    return c;
  endfunction

  logic               en;
  logic [STAGES-1:0]  vld;
  logic               last_in;
  logic [P-1:0]       a_ext;
  logic [P-1:0]       sum;
  logic [P-1:0]       out_r;

  assign en            = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = rst_n & en;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out       = out_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  if (STAGES == 1) begin : g_last1
    assign last_in = bus.in_valid;
  end else begin : g_lastn
    assign last_in = vld[STAGES-2];
  end

  assign a_ext = bus.signed_mode ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};

  for (genvar j = 0; j <= NL; j++) begin : lvl
    localparam int N = rows_at(j);
    localparam int D = regs_after(j);
    logic [N*P-1:0] c;
    logic [N*P-1:0] q;

    if (j == 0) begin : g_pp
      // Signed mode: the multiplier MSB has weight -2^(W-1), so its row is negated
      // as ~row plus a +1 carried in the extra correction row.
      always_comb begin
        c = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (bus.b[i]) c[i*P +: P] = a_ext << i;
        end
        if (bus.b[WIDTH-1])
          c[(WIDTH-1)*P +: P] = bus.signed_mode ? ~(a_ext << (WIDTH-1)) : (a_ext << (WIDTH-1));
        c[WIDTH*P] = bus.signed_mode & bus.b[WIDTH-1];
      end
    end else begin : g_csa
      localparam int M = rows_at(j - 1);
      localparam int G = M / 3;
      for (genvar g = 0; g < G; g++) begin : g_fa
        logic [P-1:0] x, y, z;
        assign x = lvl[j-1].q[(3*g)*P +: P];
        assign y = lvl[j-1].q[(3*g+1)*P +: P];
        assign z = lvl[j-1].q[(3*g+2)*P +: P];
        assign c[(2*g)*P +: P]   = x ^ y ^ z;
        assign c[(2*g+1)*P +: P] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      if (M % 3 == 2) begin : g_ha
        logic [P-1:0] x, y;
        assign x = lvl[j-1].q[(3*G)*P +: P];
        assign y = lvl[j-1].q[(3*G+1)*P +: P];
        assign c[(2*G)*P +: P]   = x ^ y;
        assign c[(2*G+1)*P +: P] = (x & y) << 1;
      end else if (M % 3 == 1) begin : g_pass
        assign c[(2*G)*P +: P] = lvl[j-1].q[(3*G)*P +: P];
      end
    end

    for (genvar k = 0; k < D; k++) begin : g_dly
      logic [N*P-1:0] r;
      if (k == 0) begin : g_first
        always_ff @(posedge clk) if (en) r <= c;
      end else begin : g_next
        always_ff @(posedge clk) if (en) r <= g_dly[k-1].r;
      end
    end

    if (D == 0) begin : g_comb
      assign q = c;
    end else begin : g_reg
      assign q = g_dly[D-1].r;
    end
  end

  assign sum = lvl[NL].q[0 +: P] + lvl[NL].q[P +: P];

  // Only load on a valid result so out never picks up unreset pipeline contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_r <= '0;
    else if (en && last_in) out_r <= sum;
  end
endmodule

// File: doc/pipe_mult_wt.md
PIPE_MULT_WT -- requirements
Module: pipe_mult_wt

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter STAGES, default 3, pipeline register stages from acceptance to result (legal 1..6).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port signed_mode, input, 1; 1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port out_valid, output, 1, result present on out.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-012 SHALL have port out, output, 2*WIDTH, product.

Function
REQ-013 SHALL accept a transfer when in_valid & in_ready are both 1 at a rising clk edge; a, b and signed_mode are sampled together.
REQ-014 SHALL compute out = a*b exactly, full 2*WIDTH bits, with no truncation or saturation; unsigned when signed_mode=0, signed with sign-extended partial products when signed_mode=1.
REQ-015 SHALL reduce partial products with a Wallace-tree (carry-save 3:2/2:2 compressor) structure and a final carry-propagate adder, with the reduction levels distributed across the STAGES registers.
REQ-016 SHALL give a latency of exactly STAGES cycles from the accepting edge to out_valid=1 when there is no stall.
REQ-017 SHALL sustain throughput of one accepted pair per cycle while out_ready=1.
REQ-018 SHALL carry one valid bit per stage; bubbles propagate and are not compressed.
REQ-019 SHALL use a global advance enable en = out_ready | ~out_valid; all stages, including their valid bits, move only when en=1.
REQ-020 SHALL drive in_ready = en while rst_n=1, and in_ready = 0 while rst_n=0.
REQ-021 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0; no result is lost, duplicated or reordered.
REQ-022 SHALL clear out_valid on the edge where out_valid=1 and out_ready=1, unless a new valid result advances in on that same edge.
REQ-023 SHALL allow a simultaneous accept at the input and a consume at the output in one cycle.
REQ-024 SHALL deliver results in acceptance order, each tagged with its own sampled signed_mode; a mixed-mode stream is legal.
REQ-025 SHALL not sample operands when in_valid=0 or in_ready=0; the value of out while out_valid=0 is don't-care but not X after reset.

Reset
REQ-026 SHALL, on rst_n low, immediately (asynchronously) clear all stage valid bits, set out_valid=0 and out=0, and discard in-flight operations.
REQ-027 SHALL leave data registers other than out unreset; they are don't-care.
REQ-028 SHALL accept input on the first rising edge after rst_n deasserts, with in_ready=1 from that point.

Verification (WIDTH=16, STAGES=3 unless stated)
REQ-029 SHALL pass: unsigned a=0xFFFF, b=0xFFFF -> out=0xFFFE0001, out_valid exactly 3 cycles after accept.
REQ-030 SHALL pass: signed a=0x8000, b=0x8000 -> 0x40000000; signed 0xFFFF*0x0001 -> 0xFFFFFFFF; unsigned 0xFFFF*0x0001 -> 0x0000FFFF.
REQ-031 SHALL pass: 10 back-to-back pairs (0*0, 1*1, 3*4, 0x00FF*0x000F, 0x0F0F*0x00F0, 0xAAAA*0x5555, 0x1234*0x5678, 0x8000*0x0002, 0x7FFF*0x7FFF, 0xFFFF*0xFFFF; unsigned) at one per cycle with out_ready=1 -> 10 consecutive correct results in order, first at cycle 3.
REQ-032 SHALL pass: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, out held constant; after release, all results appear in order with none lost.
REQ-033 SHALL pass: rst_n pulsed low with 2 operations in flight -> out_valid=0 and out=0 immediately, and no stale result appears after release.
REQ-034 SHALL pass: WIDTH=8, STAGES=1, signed 0x80*0x80 -> 0x4000 one cycle after accept; random self-checking against a reference a*b for 10^4 vectors per parameter set.
